imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes a byte stream into a writable instruction memory. It is the write-side counterpart of the instruction fetch path. The fetch side reads 32-bit little-endian words from the boot region at 0xBFC00000. This block accepts a length-prefixed byte stream, assembles it into little-endian 32-bit words and issues word writes at consecutive addresses from 0xBFC00000. It holds the CPU in reset until the whole image is written.

## Interface
- ADDRESS_WIDTH, 32, width of memory write address
- DATA_WIDTH, 8, width of one stream element (byte)
- BASE_ADDR, 32'hBFC00000, address of first image byte
- MEM_BYTES, 4096, capacity of instruction memory in bytes

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a load when idle
- byte_valid  in  1  stream byte present
- byte_data  in  DATA_WIDTH  stream byte
- byte_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  word write strobe, one cycle per word
- mem_addr  out  ADDRESS_WIDTH  byte address of word, always 4-aligned
- mem_wdata  out  32  word data; first byte of word in [7:0]
- mem_wstrb  out  4  byte enables; bit i enables mem_wdata[8i+7:8i]
- busy  out  1  load in progress
- done  out  1  image fully written; held until next start
- error  out  1  length rejected; held until next start
- cpu_rst_n  out  1  CPU reset, low until done

## Operation
- States: IDLE, LEN, DATA, FLUSH, DONE, ERR.
- A byte is accepted when byte_valid && byte_ready.
- byte_ready is 1 only in LEN and DATA.
- IDLE: start moves to LEN and clears the byte counter and word index.
- LEN: accept 4 bytes forming length N, little-endian (first byte is N[7:0]).
- After the 4th length byte:
  - N == 0: go to DONE, no writes.
  - N > MEM_BYTES: go to ERR.
  - otherwise: go to DATA.
- DATA: accept bytes into a 4-byte assembly buffer, placing byte k of the word at lane k.
- When a word's 4th byte is accepted and it is not the last image byte, the next cycle has:
  - mem_we = 1
  - mem_addr = BASE_ADDR + 4*word_index
  - mem_wstrb = 4'b1111
  - word_index increments.
- Acceptance continues in DATA during that write cycle; the buffer is double-registered, so a write never stalls the stream.
- On acceptance of the N-th payload byte, go to FLUSH.
  - FLUSH issues the final write with mem_wstrb covering only the filled lanes: N%4 == 1/2/3/0 gives 0001/0011/0111/1111.
  - Unfilled lanes of mem_wdata are 0.
  - Then go to DONE.
- DONE: done = 1, cpu_rst_n = 1, busy = 0.
- ERR: error = 1, cpu_rst_n = 0, busy = 0.
- start in DONE or ERR re-enters LEN: done/error clear and cpu_rst_n goes low on the same edge.
- start while busy (LEN/DATA/FLUSH) is ignored.
- Bytes presented when byte_ready = 0 are not consumed; the source must hold them.
- mem_we is 0 in every cycle except the write cycles above.
- Counters are 32-bit. The byte counter compares to N for termination and never wraps because N ≤ MEM_BYTES.

## Timing
- Reset values:
  - byte_ready = 0, mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0, mem_wstrb = 0
  - busy = 0, done = 0, error = 0, cpu_rst_n = 0
  - state = IDLE
- rst_n low at any time, including mid-load, forces reset values immediately. The partial image is abandoned; no further writes occur.
- start sampled at cycle t → state LEN and byte_ready = 1 at t+1; busy = 1 from t+1.
- A word completed at cycle t → mem_we = 1 at t+1.
- The last payload byte accepted at t → FLUSH write at t+1 → done = 1 and cpu_rst_n = 1 at t+2.
- The 4th length byte accepted at t, with N invalid → error = 1 at t+1.
- The 4th length byte accepted at t, with N == 0 → done = 1 at t+1.
- Maximum throughput is one byte per cycle, giving one write every 4 cycles.

## Test plan
- N = 8, bytes 13,05,00,00,93,00,10,00 streamed back-to-back → two writes:
  - addr BFC00000, data 00000513, strb F
  - addr BFC00004, data 00100093, strb F
  - done at cycle 2 after the last byte.
- N = 6, bytes 11..16 → writes:
  - BFC00000: 14131211, strb F
  - BFC00004: 00001615, strb 3.
- N = 0 → no mem_we; done = 1 and cpu_rst_n = 1 one cycle after the 4th length byte.
- N = MEM_BYTES+1 (0x00001001) → error = 1, byte_ready = 0, no writes. A later start clears error and reloads correctly.
- Random byte_valid gaps with N = 12 → exactly 3 writes with correct addresses and data.
  - A start pulse mid-stream changes nothing.
- rst_n asserted after 5 payload bytes → all outputs at reset values asynchronously, cpu_rst_n = 0.
  - A new start then loads N = 4 cleanly to BFC00000.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time program loader. It takes a length-prefixed byte stream and packs
// it into little-endian 32-bit words. The words are written to instruction
// memory at consecutive addresses starting at BASE_ADDR. The CPU is held in
// reset until the whole image has been written.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   start                 one-cycle pulse; begins a load when not busy
//   byte_valid/byte_data  incoming stream byte
//   byte_ready            loader accepts a byte this cycle (LEN/DATA only)
//   mem_we                word write strobe, one cycle per word
//   mem_addr              4-aligned byte address of the word
//   mem_wdata             word data; the first stream byte is in [7:0]
//   mem_wstrb             byte-lane enables for mem_wdata
//   busy                  load in progress
//   done                  image fully written; held until the next start
//   error                 image length rejected; held until the next start
//   cpu_rst_n             CPU reset, released only once done
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start after reset
// LEN     | collecting the 4-byte little-endian image length
// DATA    | collecting payload bytes, writing each full word
// FLUSH   | final (possibly partial) word write is on the bus
// DONE    | image written, CPU released
// ERR     | length was larger than the memory, CPU held in reset

module imem_loader #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'hBFC00000,
  parameter int                       MEM_BYTES     = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [DATA_WIDTH-1:0]    byte_data,
  output logic                     byte_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wstrb,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     cpu_rst_n
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_t      state;
  logic [31:0] byte_cnt;
  logic [31:0] word_idx;
  logic [31:0] len;
  logic [31:0] asm_buf;

  logic        accept;
  logic [1:0]  lane;
  logic [31:0] cnt_next;
  logic [31:0] asm_next;
  logic [31:0] len_next;
  logic [3:0]  tail_strb;

  assign accept   = byte_valid && byte_ready;
  assign lane     = byte_cnt[1:0];
  assign cnt_next = byte_cnt + 32'd1;

  // The incoming byte drops into its lane of either the length register or
  // the word assembly buffer. The byte counter's low bits select the lane.
  always_comb begin
    asm_next = asm_buf;
    asm_next[8*lane +: 8] = byte_data;
    len_next = len;
    len_next[8*lane +: 8] = byte_data;
  end

  // Enables for the last word depend only on N mod 4.
  always_comb begin
    tail_strb = 4'b1111;
    case (len[1:0])
      2'd1:    tail_strb = 4'b0001;
      2'd2:    tail_strb = 4'b0011;
      2'd3:    tail_strb = 4'b0111;
      default: tail_strb = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= 32'd0;
      word_idx   <= 32'd0;
      len        <= 32'd0;
      asm_buf    <= 32'd0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_rst_n  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN;
            byte_cnt   <= 32'd0;
            word_idx   <= 32'd0;
            len        <= 32'd0;
            asm_buf    <= 32'd0;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_rst_n  <= 1'b0;
          end
        end

        LEN: begin
          if (accept) begin
            len      <= len_next;
            byte_cnt <= cnt_next;
            if (lane == 2'd3) begin
              // The counter is reused for payload bytes.
              byte_cnt <= 32'd0;
              if (len_next == 32'd0) begin
                state      <= DONE;
                byte_ready <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                cpu_rst_n  <= 1'b1;
              end else if (len_next > MEM_LIMIT) begin
                state      <= ERR;
                byte_ready <= 1'b0;
                busy       <= 1'b0;
                error      <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end

        DATA: begin
          if (accept) begin
            byte_cnt <= cnt_next;
            if (cnt_next == len) begin
              // Last payload byte: the write goes out while in FLUSH.
              // The buffer is cleared after every word, so unfilled lanes
              // are already zero.
              state      <= FLUSH;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
              mem_addr   <= BASE_ADDR + ADDRESS_WIDTH'(word_idx << 2);
              mem_wdata  <= asm_next;
              mem_wstrb  <= tail_strb;
              asm_buf    <= 32'd0;
            end else if (lane == 2'd3) begin
              // The completed word moves to the output register. The
              // assembly buffer restarts, so the stream does not stall.
              mem_we    <= 1'b1;
              mem_addr  <= BASE_ADDR + ADDRESS_WIDTH'(word_idx << 2);
              mem_wdata <= asm_next;
              mem_wstrb <= 4'b1111;
              word_idx  <= word_idx + 32'd1;
              asm_buf   <= 32'd0;
            end else begin
              asm_buf <= asm_next;
            end
          end
        end

        FLUSH: begin
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          cpu_rst_n <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed bench for imem_loader. Expected memory writes go into a queue
// when the matching stimulus is planned. A monitor compares each write
// against the queue on the falling clock edge.

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_rst_n;

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_rst_n  (cpu_rst_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t exp_q[$];
  int  passed = 0;
  int  total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.strb = strb;
    exp_q.push_back(e);
  endtask

  // Write monitor. A write that the queue does not predict is an error.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {31'd0, mem_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
        check("wr_strb", {28'd0, mem_wstrb}, {28'd0, e.strb});
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_we"},    {31'd0, mem_we},     32'd0);
    check({tag, "_addr"},  mem_addr,            32'hBFC00000);
    check({tag, "_wdata"}, mem_wdata,           32'd0);
    check({tag, "_wstrb"}, {28'd0, mem_wstrb},  32'd0);
    check({tag, "_busy"},  {31'd0, busy},       32'd0);
    check({tag, "_done"},  {31'd0, done},       32'd0);
    check({tag, "_error"}, {31'd0, error},      32'd0);
    check({tag, "_cpurst"}, {31'd0, cpu_rst_n}, 32'd0);
  endtask

  // Called just after a rising edge; returns just after the edge on which
  // the pulse was sampled.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Presents a byte after 'gap' idle cycles and returns 1 time unit after
  // the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    while (byte_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (byte_ready !== 1'b1) begin
      check("ready_timeout", {31'd0, byte_ready}, 32'd1);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n, input int maxgap);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] img8 [8] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

  initial begin
    // Reset state
    #12;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("idle_ready", {31'd0, byte_ready}, 32'd0);

    // N = 8, back-to-back
    expect_write(32'hBFC00000, 32'h00000513, 4'hF);
    expect_write(32'hBFC00004, 32'h00100093, 4'hF);
    pulse_start();
    check("start_ready", {31'd0, byte_ready}, 32'd1);
    check("start_busy",  {31'd0, busy},       32'd1);
    send_len(32'd8, 0);
    for (int i = 0; i < 8; i++) send_byte(img8[i], 0);
    check("n8_flush_we",   {31'd0, mem_we},    32'd1);
    check("n8_done_early", {31'd0, done},      32'd0);
    tick(1);
    check("n8_done",   {31'd0, done},      32'd1);
    check("n8_cpurst", {31'd0, cpu_rst_n}, 32'd1);
    check("n8_busy",   {31'd0, busy},      32'd0);
    tick(2);
    check("n8_left", exp_q.size(), 32'd0);

    // N = 6, partial last word
    expect_write(32'hBFC00000, 32'h14131211, 4'hF);
    expect_write(32'hBFC00004, 32'h00001615, 4'h3);
    pulse_start();
    check("n6_done_clr",   {31'd0, done},      32'd0);
    check("n6_cpurst_low", {31'd0, cpu_rst_n}, 32'd0);
    send_len(32'd6, 0);
    for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), 0);
    tick(1);
    check("n6_done", {31'd0, done}, 32'd1);
    tick(2);
    check("n6_left", exp_q.size(), 32'd0);

    // N = 0: done one cycle after the last length byte, no writes
    pulse_start();
    send_len(32'd0, 0);
    check("n0_done",   {31'd0, done},       32'd1);
    check("n0_cpurst", {31'd0, cpu_rst_n},  32'd1);
    check("n0_ready",  {31'd0, byte_ready}, 32'd0);
    check("n0_busy",   {31'd0, busy},       32'd0);
    tick(3);
    check("n0_left", exp_q.size(), 32'd0);

    // N = MEM_BYTES + 1: rejected, then a clean reload
    pulse_start();
    send_len(32'h00001001, 0);
    check("big_error",  {31'd0, error},      32'd1);
    check("big_ready",  {31'd0, byte_ready}, 32'd0);
    check("big_cpurst", {31'd0, cpu_rst_n},  32'd0);
    check("big_done",   {31'd0, done},       32'd0);
    tick(3);
    check("big_error_held", {31'd0, error}, 32'd1);
    expect_write(32'hBFC00000, 32'hDDCCBBAA, 4'hF);
    pulse_start();
    check("reload_err_clr", {31'd0, error}, 32'd0);
    check("reload_busy",    {31'd0, busy},  32'd1);
    send_len(32'd4, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    tick(1);
    check("reload_done", {31'd0, done}, 32'd1);
    tick(2);
    check("reload_left", exp_q.size(), 32'd0);

    // N = 12 with random gaps and a stray start mid-stream
    expect_write(32'hBFC00000, 32'hA3A2A1A0, 4'hF);
    expect_write(32'hBFC00004, 32'hA7A6A5A4, 4'hF);
    expect_write(32'hBFC00008, 32'hABAAA9A8, 4'hF);
    pulse_start();
    send_len(32'd12, 3);
    for (int i = 0; i < 12; i++) begin
      send_byte(8'hA0 + 8'(i), $urandom_range(0, 3));
      if (i == 5) begin
        pulse_start();
        check("mid_start_busy",  {31'd0, busy},       32'd1);
        check("mid_start_ready", {31'd0, byte_ready}, 32'd1);
      end
    end
    tick(1);
    check("gap_done", {31'd0, done}, 32'd1);
    tick(2);
    check("gap_left", exp_q.size(), 32'd0);

    // Reset after 5 payload bytes of a 16-byte image
    expect_write(32'hBFC00000, 32'h04030201, 4'hF);
    pulse_start();
    send_len(32'd16, 0);
    for (int i = 0; i < 5; i++) send_byte(8'h01 + 8'(i), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    tick(3);
    check("midrst_hold_busy", {31'd0, busy}, 32'd0);
    check("midrst_left", exp_q.size(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    expect_write(32'hBFC00000, 32'hC3C2C1C0, 4'hF);
    pulse_start();
    send_len(32'd4, 0);
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 0);
    tick(1);
    check("post_done",   {31'd0, done},      32'd1);
    check("post_cpurst", {31'd0, cpu_rst_n}, 32'd1);
    tick(2);
    check("post_left", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
